// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared size codes, arbiter state type and size decode for mem_arbiter
package mem_arb_pkg;

    localparam logic [1:0] SIZE_BYTE      = 2'b00;
    localparam logic [1:0] SIZE_HALF_WORD = 2'b01;
    localparam logic [1:0] SIZE_WORD      = 2'b10;

    typedef enum logic {
        RR     = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Size code 2'b11 is treated as a word, like SIZE_WORD.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE:      return 3'd1;
            SIZE_HALF_WORD: return 3'd2;
            default:        return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester round-robin memory arbiter with r1 burst lock
// Grants are combinational; each grant yields a one-cycle response pulse in the next cycle.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_DEPTH      = 4096,
    parameter int MEM_ADDR_WIDTH = 12
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_r0_req,
    input  logic                      i_r0_we,
    input  logic [1:0]                i_r0_size,
    input  logic [MEM_ADDR_WIDTH-1:0] i_r0_addr,
    input  logic [31:0]               i_r0_wdata,
    input  logic                      i_r1_req,
    input  logic                      i_r1_we,
    input  logic [1:0]                i_r1_size,
    input  logic [MEM_ADDR_WIDTH-1:0] i_r1_addr,
    input  logic [31:0]               i_r1_wdata,
    input  logic                      i_r1_lock,
    output logic                      o_r0_gnt,
    output logic                      o_r0_rvalid,
    output logic [31:0]               o_r0_rdata,
    output logic                      o_r0_err,
    output logic                      o_r1_gnt,
    output logic                      o_r1_rvalid,
    output logic [31:0]               o_r1_rdata,
    output logic                      o_r1_err,
    output logic [MEM_ADDR_WIDTH-1:0] o_mem_addr,
    output logic                      o_mem_we,
    output logic [1:0]                o_mem_size,
    output logic [31:0]               o_mem_din,
    input  logic [31:0]               i_mem_dout
);

    localparam int EW = MEM_ADDR_WIDTH + 1;

    arb_state_e    r_state;
    arb_state_e    w_state_next;
    logic          r_last;
    logic          r_pend_valid;
    logic          r_pend_owner;
    logic          r_pend_rd;
    logic          r_pend_err;
    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_err0;
    logic          w_err1;
    logic          w_sel_err;
    logic          w_sel_we;
    logic [EW-1:0] w_end0;
    logic [EW-1:0] w_end1;

    // One extra bit so an access ending exactly at MEM_DEPTH does not wrap.
    assign w_end0 = {1'b0, i_r0_addr} + EW'(size_bytes(i_r0_size));
    assign w_end1 = {1'b0, i_r1_addr} + EW'(size_bytes(i_r1_size));
    assign w_err0 = w_end0 > EW'(MEM_DEPTH);
    assign w_err1 = w_end1 > EW'(MEM_DEPTH);

    always_comb begin
        w_gnt0       = 1'b0;
        w_gnt1       = 1'b0;
        w_state_next = r_state;
        if (!i_rst) begin
            if (r_state == LOCKED && i_r1_lock) begin
                w_gnt1 = i_r1_req;
            end else if (i_r0_req && i_r1_req) begin
                w_gnt0 = r_last;
                w_gnt1 = !r_last;
            end else begin
                w_gnt0 = i_r0_req;
                w_gnt1 = i_r1_req;
            end
            if (r_state == RR) begin
                if (w_gnt1 && i_r1_lock) w_state_next = LOCKED;
            end else if (!i_r1_lock) begin
                w_state_next = RR;
            end
        end
    end

    always_comb begin
        o_mem_addr = w_gnt1 ? i_r1_addr  : i_r0_addr;
        o_mem_size = w_gnt1 ? i_r1_size  : i_r0_size;
        o_mem_din  = w_gnt1 ? i_r1_wdata : i_r0_wdata;
        w_sel_err  = w_gnt1 ? w_err1     : w_err0;
        w_sel_we   = w_gnt1 ? i_r1_we    : i_r0_we;
        o_mem_we   = (w_gnt0 | w_gnt1) & w_sel_we & ~w_sel_err;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= RR;
            r_last       <= 1'b1;
            r_pend_valid <= 1'b0;
            r_pend_owner <= 1'b0;
            r_pend_rd    <= 1'b0;
            r_pend_err   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            if (w_gnt0 | w_gnt1) r_last <= w_gnt1;
            r_pend_valid <= w_gnt0 | w_gnt1;
            r_pend_owner <= w_gnt1;
            r_pend_rd    <= ~w_sel_we & ~w_sel_err;
            r_pend_err   <= w_sel_err;
        end
    end

    assign o_r0_gnt    = w_gnt0;
    assign o_r1_gnt    = w_gnt1;
    assign o_r0_rvalid = r_pend_valid & ~r_pend_owner;
    assign o_r1_rvalid = r_pend_valid &  r_pend_owner;
    assign o_r0_err    = o_r0_rvalid & r_pend_err;
    assign o_r1_err    = o_r1_rvalid & r_pend_err;
    assign o_r0_rdata  = (o_r0_rvalid & r_pend_rd) ? i_mem_dout : 32'h0;
    assign o_r1_rdata  = (o_r1_rvalid & r_pend_rd) ? i_mem_dout : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with directed and randomized model checks
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r0_req = 0, r0_we = 0, r1_req = 0, r1_we = 0, r1_lock = 0;
    logic [1:0]  r0_size = 0, r1_size = 0;
    logic [11:0] r0_addr = 0, r1_addr = 0;
    logic [31:0] r0_wdata = 0, r1_wdata = 0;
    logic        r0_gnt, r0_rvalid, r0_err, r1_gnt, r1_rvalid, r1_err;
    logic [31:0] r0_rdata, r1_rdata;
    logic [11:0] mem_addr;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic [31:0] mem_din;
    logic [31:0] mem_dout = 32'h0;

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0] mem    [0:4095] = '{default: 8'h00};
    logic [7:0] shadow [0:4095];

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_DEPTH(4096), .MEM_ADDR_WIDTH(12)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_r0_req(r0_req), .i_r0_we(r0_we), .i_r0_size(r0_size), .i_r0_addr(r0_addr), .i_r0_wdata(r0_wdata),
        .i_r1_req(r1_req), .i_r1_we(r1_we), .i_r1_size(r1_size), .i_r1_addr(r1_addr), .i_r1_wdata(r1_wdata),
        .i_r1_lock(r1_lock),
        .o_r0_gnt(r0_gnt), .o_r0_rvalid(r0_rvalid), .o_r0_rdata(r0_rdata), .o_r0_err(r0_err),
        .o_r1_gnt(r1_gnt), .o_r1_rvalid(r1_rvalid), .o_r1_rdata(r1_rdata), .o_r1_err(r1_err),
        .o_mem_addr(mem_addr), .o_mem_we(mem_we), .o_mem_size(mem_size), .o_mem_din(mem_din),
        .i_mem_dout(mem_dout)
    );

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [7:0] mem_byte(input int a);
        return (a < 4096) ? mem[a] : 8'h00;
    endfunction

    function automatic logic [31:0] shadow_word(input int a);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = (a + k < 4096) ? shadow[a + k] : 8'h00;
        return w;
    endfunction

    // Byte-addressed little-endian memory: registered read, sized write.
    always @(posedge clk) begin
        mem_dout <= {mem_byte(int'(mem_addr) + 3), mem_byte(int'(mem_addr) + 2),
                     mem_byte(int'(mem_addr) + 1), mem_byte(int'(mem_addr))};
        if (mem_we)
            for (int k = 0; k < nbytes(mem_size); k++) mem[int'(mem_addr) + k] = mem_din[8*k +: 8];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic drive_idle();
        r0_req = 0; r0_we = 0; r0_size = 0; r0_addr = 0; r0_wdata = 0;
        r1_req = 0; r1_we = 0; r1_size = 0; r1_addr = 0; r1_wdata = 0; r1_lock = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive_idle();
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1; r0_req = 1; r0_we = 1; r1_req = 1; r1_we = 1;
        #1;
        n_vec++; if (r0_gnt !== 1'b0)    begin n_bad++; $display("FAIL rst_gnt0 got=%b exp=0", r0_gnt); end
        n_vec++; if (r1_gnt !== 1'b0)    begin n_bad++; $display("FAIL rst_gnt1 got=%b exp=0", r1_gnt); end
        n_vec++; if (mem_we !== 1'b0)    begin n_bad++; $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
        n_vec++; if (r0_rvalid !== 1'b0) begin n_bad++; $display("FAIL rst_rvalid0 got=%b exp=0", r0_rvalid); end
        n_vec++; if (r1_rvalid !== 1'b0) begin n_bad++; $display("FAIL rst_rvalid1 got=%b exp=0", r1_rvalid); end
        n_vec++; if (r0_err !== 1'b0)    begin n_bad++; $display("FAIL rst_err0 got=%b exp=0", r0_err); end
        n_vec++; if (r1_err !== 1'b0)    begin n_bad++; $display("FAIL rst_err1 got=%b exp=0", r1_err); end
        n_vec++; if (r0_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata0 got=%h exp=0", r0_rdata); end
        n_vec++; if (r1_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata1 got=%h exp=0", r1_rdata); end
        @(posedge clk); #1;
        n_vec++; if (r0_rvalid !== 1'b0) begin n_bad++; $display("FAIL rst_hold_rvalid0 got=%b exp=0", r0_rvalid); end
        @(negedge clk);
        drive_idle();
        rst = 0;
    endtask

    task automatic test_tie_alternation();
        logic [31:0] exp_d;
        @(negedge clk); r1_req = 1; r1_we = 1; r1_size = 2'b10; r1_addr = 12'h010; r1_wdata = 32'hA0B0C0D0;
        @(negedge clk); r1_addr = 12'h020; r1_wdata = 32'h01020304;
        @(negedge clk); drive_idle();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            r0_req = 1; r0_we = 0; r0_size = 2'b10; r0_addr = 12'h010;
            r1_req = 1; r1_we = 0; r1_size = 2'b10; r1_addr = 12'h020;
            #1;
            n_vec++; if (r0_gnt !== (i % 2 == 0)) begin n_bad++; $display("FAIL tie_gnt0 i=%0d got=%b exp=%b", i, r0_gnt, i % 2 == 0); end
            n_vec++; if (r1_gnt !== (i % 2 == 1)) begin n_bad++; $display("FAIL tie_gnt1 i=%0d got=%b exp=%b", i, r1_gnt, i % 2 == 1); end
            n_vec++; if (mem_addr !== ((i % 2 == 0) ? 12'h010 : 12'h020))
                begin n_bad++; $display("FAIL tie_mem_addr i=%0d got=%h", i, mem_addr); end
            @(posedge clk); #1;
            exp_d = (i % 2 == 0) ? 32'hA0B0C0D0 : 32'h01020304;
            n_vec++; if (r0_rvalid !== (i % 2 == 0)) begin n_bad++; $display("FAIL tie_rvalid0 i=%0d got=%b", i, r0_rvalid); end
            n_vec++; if (r1_rvalid !== (i % 2 == 1)) begin n_bad++; $display("FAIL tie_rvalid1 i=%0d got=%b", i, r1_rvalid); end
            n_vec++; if (((i % 2 == 0) ? r0_rdata : r1_rdata) !== exp_d)
                begin n_bad++; $display("FAIL tie_rdata i=%0d got0=%h got1=%h exp=%h", i, r0_rdata, r1_rdata, exp_d); end
        end
        @(negedge clk); drive_idle();
    endtask

    task automatic test_lock();
        logic [3:0] exp_g1 = 4'b1011;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            r1_req = (c != 2); r1_lock = (c < 4); r1_we = 1; r1_size = 2'b10; r1_addr = 12'h100; r1_wdata = 32'hDEADBEEF;
            r0_req = (c > 0); r0_we = 0; r0_size = 2'b10; r0_addr = 12'h010;
            #1;
            n_vec++; if (r0_gnt !== (c == 4)) begin n_bad++; $display("FAIL lock_gnt0 c=%0d got=%b exp=%b", c, r0_gnt, c == 4); end
            n_vec++; if (r1_gnt !== ((c < 4) ? exp_g1[c] : 1'b0))
                begin n_bad++; $display("FAIL lock_gnt1 c=%0d got=%b", c, r1_gnt); end
            @(posedge clk);
        end
        #1;
        n_vec++; if (r0_rvalid !== 1'b1 || r0_rdata !== 32'hA0B0C0D0)
            begin n_bad++; $display("FAIL lock_r0_resp got=%b/%h exp=1/a0b0c0d0", r0_rvalid, r0_rdata); end
        n_vec++; if ({mem[259], mem[258], mem[257], mem[256]} !== 32'hDEADBEEF)
            begin n_bad++; $display("FAIL lock_mem got=%h exp=deadbeef", {mem[259], mem[258], mem[257], mem[256]}); end
        @(negedge clk); drive_idle();
    endtask

    task automatic test_bounds();
        @(negedge clk); r0_req = 1; r0_we = 1; r0_size = 2'b10; r0_addr = 12'hFFE; r0_wdata = 32'h12345678;
        #1;
        n_vec++; if (r0_gnt !== 1'b1) begin n_bad++; $display("FAIL oob_gnt got=%b exp=1", r0_gnt); end
        n_vec++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL oob_mem_we got=%b exp=0", mem_we); end
        @(posedge clk); #1;
        n_vec++; if ({r0_rvalid, r0_err} !== 2'b11 || r0_rdata !== 32'h0)
            begin n_bad++; $display("FAIL oob_resp got=%b%b/%h exp=11/0", r0_rvalid, r0_err, r0_rdata); end
        n_vec++; if (mem[4094] !== 8'h00) begin n_bad++; $display("FAIL oob_mem got=%h exp=00", mem[4094]); end
        @(negedge clk); r0_size = 2'b00; r0_addr = 12'hFFF; r0_wdata = 32'h0000005A;
        #1;
        n_vec++; if (r0_gnt !== 1'b1 || mem_we !== 1'b1) begin n_bad++; $display("FAIL top_byte_we got=%b%b exp=11", r0_gnt, mem_we); end
        @(posedge clk); #1;
        n_vec++; if ({r0_rvalid, r0_err} !== 2'b10 || r0_rdata !== 32'h0)
            begin n_bad++; $display("FAIL top_byte_resp got=%b%b/%h exp=10/0", r0_rvalid, r0_err, r0_rdata); end
        n_vec++; if (mem[4095] !== 8'h5A) begin n_bad++; $display("FAIL top_byte_mem got=%h exp=5a", mem[4095]); end
        @(negedge clk); r0_we = 0; r0_size = 2'b01; r0_addr = 12'hFFF;
        @(posedge clk); #1;
        n_vec++; if ({r0_rvalid, r0_err} !== 2'b11 || r0_rdata !== 32'h0)
            begin n_bad++; $display("FAIL oob_read got=%b%b/%h exp=11/0", r0_rvalid, r0_err, r0_rdata); end
        @(negedge clk); drive_idle();
    endtask

    task automatic test_half_write_read();
        @(negedge clk); r0_req = 1; r0_we = 1; r0_size = 2'b01; r0_addr = 12'h004; r0_wdata = 32'hFFFFA5A5;
        #1;
        n_vec++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL half_we got=%b exp=1", mem_we); end
        @(negedge clk); r0_we = 0; r0_size = 2'b10;
        @(posedge clk); #1;
        n_vec++; if (r0_rvalid !== 1'b1 || r0_rdata !== 32'h0000A5A5)
            begin n_bad++; $display("FAIL half_readback got=%b/%h exp=1/0000a5a5", r0_rvalid, r0_rdata); end
        @(negedge clk); drive_idle();
    endtask

    task automatic test_reset_midflight();
        @(negedge clk); r0_req = 1; r0_we = 0; r0_size = 2'b10; r0_addr = 12'h010;
        #1;
        n_vec++; if (r0_gnt !== 1'b1) begin n_bad++; $display("FAIL mid_gnt got=%b exp=1", r0_gnt); end
        @(posedge clk); #1;
        rst = 1; drive_idle();
        #1;
        n_vec++; if (r0_rvalid !== 1'b0) begin n_bad++; $display("FAIL mid_rvalid_in_rst got=%b exp=0", r0_rvalid); end
        repeat (2) @(negedge clk);
        rst = 0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            n_vec++; if (r0_rvalid !== 1'b0 || r1_rvalid !== 1'b0)
                begin n_bad++; $display("FAIL mid_stale_rvalid i=%0d got=%b%b exp=00", i, r0_rvalid, r1_rvalid); end
        end
        @(negedge clk); r0_req = 1; r1_req = 1; r0_size = 2'b10; r1_size = 2'b10;
        #1;
        n_vec++; if ({r0_gnt, r1_gnt} !== 2'b10) begin n_bad++; $display("FAIL mid_first_tie got=%b%b exp=10", r0_gnt, r1_gnt); end
        @(negedge clk); drive_idle();
    endtask

    task automatic test_random();
        int          last_id = 1;
        bit          locked = 0;
        bit          p_valid = 0, p_owner = 0, p_err = 0;
        logic [31:0] p_data = 0;
        bit          e0, e1, ew, er;
        int          ga, gn;
        int          a;
        do_reset();
        for (int i = 0; i < 4096; i++) shadow[i] = mem[i];
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            r0_req = ($urandom_range(0, 3) != 0); r1_req = ($urandom_range(0, 2) != 0);
            r0_we = $urandom_range(0, 1); r1_we = $urandom_range(0, 1);
            r0_size = 2'($urandom_range(0, 3)); r1_size = 2'($urandom_range(0, 3));
            a = $urandom_range(0, 1) ? $urandom_range(0, 4095) : $urandom_range(4088, 4095); r0_addr = 12'(a);
            a = $urandom_range(0, 1) ? $urandom_range(0, 4095) : $urandom_range(4088, 4095); r1_addr = 12'(a);
            r0_wdata = $urandom; r1_wdata = $urandom;
            if ($urandom_range(0, 5) == 0) r1_lock = ~r1_lock;
            #1;
            if (locked && r1_lock) begin e0 = 0; e1 = r1_req; end
            else if (r0_req && r1_req) begin e0 = (last_id == 1); e1 = (last_id == 0); end
            else begin e0 = r0_req; e1 = r1_req; end
            ga = e1 ? int'(r1_addr) : int'(r0_addr);
            gn = e1 ? nbytes(r1_size) : nbytes(r0_size);
            er = (ga + gn > 4096);
            ew = e1 ? r1_we : r0_we;
            n_vec++; if (r0_gnt !== e0) begin n_bad++; $display("FAIL rnd_gnt0 cyc=%0d got=%b exp=%b", cyc, r0_gnt, e0); end
            n_vec++; if (r1_gnt !== e1) begin n_bad++; $display("FAIL rnd_gnt1 cyc=%0d got=%b exp=%b", cyc, r1_gnt, e1); end
            n_vec++; if (mem_we !== ((e0 || e1) && ew && !er))
                begin n_bad++; $display("FAIL rnd_mem_we cyc=%0d got=%b", cyc, mem_we); end
            if (e0 || e1) begin
                n_vec++; if (int'(mem_addr) !== ga) begin n_bad++; $display("FAIL rnd_mem_addr cyc=%0d got=%h exp=%h", cyc, mem_addr, ga); end
            end
            n_vec++; if (r0_rvalid !== (p_valid && !p_owner) || r1_rvalid !== (p_valid && p_owner))
                begin n_bad++; $display("FAIL rnd_rvalid cyc=%0d got=%b%b", cyc, r0_rvalid, r1_rvalid); end
            n_vec++; if (r0_err !== (p_valid && !p_owner && p_err) || r1_err !== (p_valid && p_owner && p_err))
                begin n_bad++; $display("FAIL rnd_err cyc=%0d got=%b%b", cyc, r0_err, r1_err); end
            n_vec++; if (r0_rdata !== ((p_valid && !p_owner) ? p_data : 32'h0) || r1_rdata !== ((p_valid && p_owner) ? p_data : 32'h0))
                begin n_bad++; $display("FAIL rnd_rdata cyc=%0d got0=%h got1=%h exp=%h", cyc, r0_rdata, r1_rdata, p_data); end
            p_valid = e0 || e1;
            if (p_valid) begin
                last_id = e1 ? 1 : 0;
                p_owner = e1;
                p_err   = er;
                p_data  = (ew || er) ? 32'h0 : shadow_word(ga);
                if (ew && !er)
                    for (int k = 0; k < gn; k++) shadow[ga + k] = e1 ? r1_wdata[8*k +: 8] : r0_wdata[8*k +: 8];
            end
            locked = r1_lock && (locked || e1);
            @(posedge clk);
        end
        @(negedge clk); drive_idle();
    endtask

    initial begin
        test_reset();
        test_tie_alternation();
        test_lock();
        test_bounds();
        test_half_write_read();
        test_reset_midflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
